boolean_sweep_checker: RTL and testbench
========================================

// Module: boolean_sweep_checker
// PURPOSE
//  Sequential stimulus/checker stage that sits directly upstream of the minimised
//  Boolean-function block (F1 over a,b,c,d; F2 over w,x,y,z).
//  On start it drives all 16 input minterms in order and samples F1/F2 back.
//  It builds 16-bit truth tables, compares them against the expected minterm masks,
//  and reports pass/fail plus the first failing index.
//  F1 and F2 are tested together: both input vectors take the same 4-bit index.
// PARAMETERS
//  SETTLE_CYCLES  1        cycles a vector is held before sampling; legal range 1..15
//  EXP_F1         16'h35A5 expected F1 table, bit i = F1 at {a,b,c,d}=i (minterms 0,2,5,7,8,10,12,13)
//  EXP_F2         16'hEEE2 expected F2 table, bit i = F2 at {w,x,y,z}=i (minterms 1,5,6,7,9,10,11,13,14,15)
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   request a sweep; sampled only in IDLE
//  a,b,c,d     out  1   F1 inputs, registered; {a,b,c,d} = idx (a is MSB)
//  w,x,y,z     out  1   F2 inputs, registered; {w,x,y,z} = idx (w is MSB)
//  f1_in       in   1   F1 result returned from the function block
//  f2_in       in   1   F2 result returned from the function block
//  busy        out  1   high from start acceptance until the cycle before done
//  done        out  1   one-cycle pulse when the sweep completes
//  pass        out  1   tables matched expected; valid from done, held until next start
//  fail_valid  out  1   a mismatch has occurred in the current or last sweep
//  fail_idx    out  4   index of the first mismatch; meaningful only when fail_valid
//  tt_f1       out  16  captured F1 truth table
//  tt_f2       out  16  captured F2 truth table
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, idx 0, settle counter 0.
//  States and transitions:
//   IDLE   -> SETTLE   when start=1. On this edge: idx<=0, clear tt_f1, tt_f2, pass,
//                      fail_valid and fail_idx; busy<=1.
//   SETTLE -> SAMPLE   once SETTLE_CYCLES cycles have been spent in SETTLE.
//   SAMPLE             tt_f1[idx]<=f1_in and tt_f2[idx]<=f2_in.
//                      On the first mismatch against EXP_F1[idx] or EXP_F2[idx]:
//                      fail_valid<=1 and fail_idx<=idx. Later mismatches do not change fail_idx.
//                      If idx==15 -> DONE; otherwise idx<=idx+1 -> SETTLE.
//   DONE   -> IDLE     done=1 for this cycle only; busy=0.
//                      pass = (tt_f1==EXP_F1)&&(tt_f2==EXP_F2), i.e. !fail_valid.
//  Input drive: a..d and w..z follow idx in every state except IDLE/DONE, where they are 0.
//  Each vector costs SETTLE_CYCLES+1 cycles.
//  Latency: done is high exactly 16*(SETTLE_CYCLES+1)+1 cycles after the start edge.
//  With the default, done rises at edge 33.
//  idx never wraps within a sweep; the index-15 sample always ends the sweep.
//  start while busy or in DONE: ignored. No restart and no state change.
//  start held high: the next sweep begins on the first IDLE cycle after DONE.
//  Back-to-back sweeps therefore have one DONE cycle plus one IDLE cycle between them.
//  rst_n low at any time, including mid-sweep: immediate return to reset values.
//  A sweep interrupted by reset produces no done pulse.
//  tt_f1, tt_f2, pass, fail_valid and fail_idx hold their values in IDLE until the next start.
// TESTING
//  Golden function block connected, start 1 cycle -> done at edge 33; pass=1,
//   tt_f1=16'h35A5, tt_f2=16'hEEE2, fail_valid=0.
//  f1_in forced 0 -> pass=0, fail_valid=1, fail_idx=0, tt_f1=16'h0000, tt_f2=16'hEEE2.
//  f2_in inverted only when idx==9 -> fail_idx=9, tt_f2=16'hECE2, tt_f1=16'h35A5, pass=0.
//  Second start pulse at cycle 10 of a sweep -> ignored; done still only at edge 33.
//  rst_n pulsed low while idx==7 -> all outputs 0 immediately, no done.
//   A fresh start then gives a full pass.
//  SETTLE_CYCLES=3 with start held high -> done at edge 65;
//   the second sweep starts on the IDLE cycle after it and passes again.

Source files
------------

// File: rtl/boolean_sweep_checker.sv
// Sweeps all 16 minterms into the F1/F2 function block, captures both
// truth tables and reports pass/fail plus the first mismatching index.
module boolean_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] EXP_F1 = 16'h35A5,
    parameter logic [15:0] EXP_F2 = 16'hEEE2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    input  logic        f1_in,
    input  logic        f2_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail_valid,
    output logic [3:0]  fail_idx,
    output logic [15:0] tt_f1,
    output logic [15:0] tt_f2
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] idx;
    logic [3:0] idx_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic [3:0] vec;
    logic [3:0] vec_nx;
    logic       mism;

    assign mism = (f1_in != EXP_F1[idx]) || (f2_in != EXP_F2[idx]);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETTLE;
                    idx_nx   = 4'd0;
                    cnt_nx   = 4'd0;
                end
            end
            SETTLE: begin
                if (cnt == LAST_SETTLE) begin
                    state_nx = SAMPLE;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            SAMPLE: begin
                if (idx == 4'd15) begin
                    state_nx = DONE;
                end else begin
                    state_nx = SETTLE;
                    idx_nx   = idx + 4'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                idx_nx   = 4'd0;
            end
            default: state_nx = IDLE;
        endcase
        // Function inputs are parked at zero outside an active sweep
        vec_nx = 4'd0;
        if (state_nx == SETTLE || state_nx == SAMPLE) begin
            vec_nx = idx_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 4'd0;
            cnt   <= 4'd0;
            vec   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
            vec   <= vec_nx;
            busy  <= (state_nx == SETTLE) || (state_nx == SAMPLE);
            done  <= (state_nx == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_f1      <= 16'h0000;
            tt_f2      <= 16'h0000;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_idx   <= 4'd0;
        end else if (state == IDLE && start) begin
            tt_f1      <= 16'h0000;
            tt_f2      <= 16'h0000;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_idx   <= 4'd0;
        end else if (state == SAMPLE) begin
            tt_f1[idx] <= f1_in;
            tt_f2[idx] <= f2_in;
            if (mism && !fail_valid) begin
                fail_valid <= 1'b1;
                fail_idx   <= idx;
            end
            // Final sample folds into the verdict visible with done
            if (idx == 4'd15) begin
                pass <= !(fail_valid || mism);
            end
        end
    end

    assign {a, b, c, d} = vec;
    assign {w, x, y, z} = vec;

endmodule

// File: tb/tb_boolean_sweep_checker.sv
// Directed bench: golden and faulty function-block models around two
// checker instances (settle 1 and settle 3).
module tb_boolean_sweep_checker;

    localparam logic [15:0] G1 = 16'h35A5;
    localparam logic [15:0] G2 = 16'hEEE2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    int          mode = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic        a1, b1, c1, d1, w1, x1, y1, z1;
    logic        f1_1, f2_1, busy1, done1, pass1, fv1;
    logic [3:0]  fidx1;
    logic [15:0] tt1_1, tt2_1;

    logic        a2, b2, c2, d2, w2, x2, y2, z2;
    logic        f1_2, f2_2, busy2, done2, pass2, fv2;
    logic [3:0]  fidx2;
    logic [15:0] tt1_2, tt2_2;

    always #5 clk = ~clk;

    // Function block model; mode selects golden or an injected fault
    always_comb begin
        f1_1 = G1[{a1, b1, c1, d1}];
        f2_1 = G2[{w1, x1, y1, z1}];
        if (mode == 1) f1_1 = 1'b0;
        if (mode == 2 && {w1, x1, y1, z1} == 4'd9) f2_1 = ~f2_1;
        f1_2 = G1[{a2, b2, c2, d2}];
        f2_2 = G2[{w2, x2, y2, z2}];
    end

    boolean_sweep_checker dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .w(w1), .x(x1), .y(y1), .z(z1),
        .f1_in(f1_1), .f2_in(f2_1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_valid(fv1), .fail_idx(fidx1),
        .tt_f1(tt1_1), .tt_f2(tt2_1)
    );

    boolean_sweep_checker #(.SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .a(a2), .b(b2), .c(c2), .d(d2),
        .w(w2), .x(x2), .y(y2), .z(z2),
        .f1_in(f1_2), .f2_in(f2_2),
        .busy(busy2), .done(done2), .pass(pass2),
        .fail_valid(fv2), .fail_idx(fidx2),
        .tt_f1(tt1_2), .tt_f2(tt2_2)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs1();
        return {16'h0, a1, b1, c1, d1, w1, x1, y1, z1,
                busy1, done1, pass1, fv1, fidx1, tt1_1, tt2_1};
    endfunction

    // Pulse start for one cycle; returns the cycle (1 = first after the
    // start edge) on which done is seen. restart_at>0 re-pulses start.
    task automatic sweep1(input int restart_at, output int cyc);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 200) begin
            start1 = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start1 = 1'b0;
    endtask

    initial begin
        int cyc;
        int k;
        repeat (2) @(negedge clk);
        chk("reset_outs1", outs1(), 64'h0);
        chk("reset_busy2_done2", {busy2, done2, pass2, fv2}, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Golden sweep, checking drive and latency along the way
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("busy_after_start", busy1, 1'b1);
        chk("vec_cyc1", {a1, b1, c1, d1}, 4'd0);
        @(negedge clk);
        @(negedge clk);
        chk("vec_cyc3", {a1, b1, c1, d1}, 4'd1);
        chk("wxyz_cyc3", {w1, x1, y1, z1}, 4'd1);
        @(negedge clk);
        @(negedge clk);
        chk("vec_cyc5", {w1, x1, y1, z1}, 4'd2);
        cyc = 5;
        while (!done1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("gold_done_cycle", cyc, 33);
        chk("gold_busy_at_done", busy1, 1'b0);
        chk("gold_pass", pass1, 1'b1);
        chk("gold_fv", fv1, 1'b0);
        chk("gold_tt_f1", tt1_1, G1);
        chk("gold_tt_f2", tt2_1, G2);
        @(negedge clk);
        chk("done_one_cycle", done1, 1'b0);
        chk("idle_vec_zero", {a1, b1, c1, d1, w1, x1, y1, z1}, 8'h0);
        repeat (3) @(negedge clk);
        chk("idle_hold", {pass1, tt1_1, tt2_1}, {1'b1, G1, G2});

        // F1 stuck at zero
        mode = 1;
        sweep1(0, cyc);
        chk("f1z_done_cycle", cyc, 33);
        chk("f1z_pass", pass1, 1'b0);
        chk("f1z_fv", fv1, 1'b1);
        chk("f1z_fidx", fidx1, 4'd0);
        chk("f1z_tt_f1", tt1_1, 16'h0000);
        chk("f1z_tt_f2", tt2_1, G2);
        @(negedge clk);

        // F2 inverted at index 9 only
        mode = 2;
        sweep1(0, cyc);
        chk("f2x9_fidx", fidx1, 4'd9);
        chk("f2x9_fv", fv1, 1'b1);
        chk("f2x9_tt_f2", tt2_1, 16'hECE2);
        chk("f2x9_tt_f1", tt1_1, G1);
        chk("f2x9_pass", pass1, 1'b0);
        @(negedge clk);

        // Start re-pulsed mid-sweep must be ignored
        mode = 0;
        sweep1(10, cyc);
        chk("restart_done_cycle", cyc, 33);
        chk("restart_pass", pass1, 1'b1);
        k = 0;
        repeat (40) begin
            @(negedge clk);
            if (done1 || busy1) k++;
        end
        chk("restart_no_second", k, 0);

        // Reset in the middle of the sweep at index 7
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        while ({a1, b1, c1, d1} != 4'd7 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_idx7", {a1, b1, c1, d1}, 4'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_outs", outs1(), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        repeat (40) begin
            @(negedge clk);
            if (done1 || busy1) k++;
        end
        chk("midreset_no_done", k, 0);
        sweep1(0, cyc);
        chk("fresh_done_cycle", cyc, 33);
        chk("fresh_pass", {pass1, fv1, tt1_1, tt2_1}, {2'b10, G1, G2});

        // Settle 3, start held high: back-to-back sweeps
        start2 = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!done2 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("s3_done_cycle", cyc, 65);
        chk("s3_pass", {pass2, tt1_2, tt2_2}, {1'b1, G1, G2});
        @(negedge clk);
        chk("s3_idle_gap", {busy2, done2}, 2'b00);
        @(negedge clk);
        chk("s3_second_busy", busy2, 1'b1);
        cyc = 1;
        while (!done2 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        start2 = 1'b0;
        chk("s3_second_done_cycle", cyc, 65);
        chk("s3_second_pass", {pass2, fv2}, 2'b10);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
